// File: rtl/gamma_pkg.sv
// ---------------------------------------------------------------------------
// gamma_pkg
//   Shared types and limits for the gamma LUT video stage.
//   - gamma_state_t : frame-lock FSM states (SYNC_WAIT, RUN)
//   - DATA_W_DEF    : default per-channel pixel / ROM address width
//   - ROM_LAT_MIN/MAX : supported gamma ROM read latencies
//   - DE_COUNT_W    : width of the optional active-pixel counter
//                     (present only when GAMMA_DE_COUNT_EN is defined)
// ---------------------------------------------------------------------------
package gamma_pkg;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } gamma_state_t;

  localparam int DATA_W_DEF  = 8;
  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 2;
  localparam int DE_COUNT_W  = 24;

endpackage

// File: rtl/video_delay_line.sv
// ---------------------------------------------------------------------------
// video_delay_line
//   Fixed-depth shift register used to line up syncs and raw pixels with the
//   gamma ROM read data. Every stage clears to 0 on synchronous reset.
//   Parameters : WIDTH (bits per stage), DEPTH (stages, >= 1)
//   Ports      : clk, rst (sync, active-high), d (input word), q (d delayed
//                by DEPTH cycles)
// ---------------------------------------------------------------------------
module video_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/gamma_lut_stage.sv
// ---------------------------------------------------------------------------
// gamma_lut_stage
//   Per-channel gamma correction through three external gamma ROMs. Pixel
//   values address the ROMs directly; syncs and raw pixels are delayed by the
//   ROM read latency so they line up with the ROM data, then one output
//   register stage selects corrected or raw pixels.
//
//   Output is held blank after reset until the first vs rising edge so the
//   first frame we emit is a complete one. The bypass request is only taken
//   at a vs rising edge so a frame is never half corrected.
//
//   Parameters : DATA_W  - pixel / ROM address / ROM data width
//                ROM_LAT - gamma ROM read latency, 1 or 2 cycles
//   Ports      : clk, rst (sync, active-high)
//                i_vs/i_hs/i_de, i_r/i_g/i_b   upstream video
//                bypass                        bypass request
//                rom_addr_r/g/b                ROM addresses (combinational)
//                rom_data_r/g/b                ROM read data
//                o_vs/o_hs/o_de, o_r/o_g/o_b   corrected video, latency
//                                              ROM_LAT+1
//                bypass_act                    bypass state in effect
//                de_count                      active pixels of the last
//                                              complete frame (only with
//                                              GAMMA_DE_COUNT_EN defined)
//   Build option: `define GAMMA_DE_COUNT_EN adds the de_count port/counter.
// ---------------------------------------------------------------------------
module gamma_lut_stage
  import gamma_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vs,
  input  logic              i_hs,
  input  logic              i_de,
  input  logic [DATA_W-1:0] i_r,
  input  logic [DATA_W-1:0] i_g,
  input  logic [DATA_W-1:0] i_b,
  input  logic              bypass,
  output logic [DATA_W-1:0] rom_addr_r,
  output logic [DATA_W-1:0] rom_addr_g,
  output logic [DATA_W-1:0] rom_addr_b,
  input  logic [DATA_W-1:0] rom_data_r,
  input  logic [DATA_W-1:0] rom_data_g,
  input  logic [DATA_W-1:0] rom_data_b,
  output logic              o_vs,
  output logic              o_hs,
  output logic              o_de,
  output logic [DATA_W-1:0] o_r,
  output logic [DATA_W-1:0] o_g,
  output logic [DATA_W-1:0] o_b,
  output logic              bypass_act
`ifdef GAMMA_DE_COUNT_EN
  ,
  output logic [DE_COUNT_W-1:0] de_count
`endif
);

  // Out-of-range latencies are clamped to the nearest supported value so the
  // alignment depth can never be zero or exceed what the ROMs provide.
  localparam int LAT = (ROM_LAT < ROM_LAT_MIN) ? ROM_LAT_MIN :
                       (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;
  localparam int BUS_W = 3 + 3 * DATA_W;

  // Output pixel select: blank when not enabled, otherwise raw or ROM value.
  function automatic logic [DATA_W-1:0] pix_sel(
    input logic [DATA_W-1:0] raw,
    input logic [DATA_W-1:0] lut,
    input logic              byp,
    input logic              en
  );
    if (!en) begin
      return '0;
    end
    return byp ? raw : lut;
  endfunction

  // ---- stage p0: input side, ROM addressing ----
  assign rom_addr_r = i_r;
  assign rom_addr_g = i_g;
  assign rom_addr_b = i_b;

  logic [BUS_W-1:0] bus_p0;
  logic [BUS_W-1:0] bus_p1;

  assign bus_p0 = {i_vs, i_hs, i_de, i_r, i_g, i_b};

  video_delay_line #(
    .WIDTH(BUS_W),
    .DEPTH(LAT)
  ) u_align (
    .clk(clk),
    .rst(rst),
    .d  (bus_p0),
    .q  (bus_p1)
  );

  // ---- stage p1: aligned with ROM read data ----
  logic              vs_p1;
  logic              hs_p1;
  logic              de_p1;
  logic [DATA_W-1:0] raw_r_p1;
  logic [DATA_W-1:0] raw_g_p1;
  logic [DATA_W-1:0] raw_b_p1;

  assign {vs_p1, hs_p1, de_p1, raw_r_p1, raw_g_p1, raw_b_p1} = bus_p1;

  // Previous aligned vs, for rising-edge detection on the aligned timeline.
  logic vs_prev_p1;
  logic vs_rise_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_p1 <= 1'b0;
    end else begin
      vs_prev_p1 <= vs_p1;
    end
  end

  assign vs_rise_p1 = vs_p1 & ~vs_prev_p1;

  // Frame-lock FSM: state register
  gamma_state_t state_q;
  gamma_state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC_WAIT;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Frame-lock FSM: next state. RUN is left only through reset.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      SYNC_WAIT: if (vs_rise_p1) state_nxt = RUN;
      RUN:       state_nxt = RUN;
      default:   state_nxt = SYNC_WAIT;
    endcase
  end

  // Frame-lock FSM: outputs. The vs edge cycle already counts as running and
  // already uses the freshly sampled bypass, so a bypass change presented on
  // the edge takes effect on that edge.
  logic pix_en_p1;
  logic byp_nxt_p1;

  always_comb begin
    pix_en_p1  = 1'b0;
    byp_nxt_p1 = bypass_act;
    if (vs_rise_p1) begin
      byp_nxt_p1 = bypass;
    end
    if ((state_q == RUN) || vs_rise_p1) begin
      pix_en_p1 = de_p1;
    end
  end

  // ---- stage p2: registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vs       <= 1'b0;
      o_hs       <= 1'b0;
      o_de       <= 1'b0;
      o_r        <= '0;
      o_g        <= '0;
      o_b        <= '0;
      bypass_act <= 1'b0;
    end else begin
      o_vs       <= vs_p1;
      o_hs       <= hs_p1;
      o_de       <= pix_en_p1;
      o_r        <= pix_sel(raw_r_p1, rom_data_r, byp_nxt_p1, pix_en_p1);
      o_g        <= pix_sel(raw_g_p1, rom_data_g, byp_nxt_p1, pix_en_p1);
      o_b        <= pix_sel(raw_b_p1, rom_data_b, byp_nxt_p1, pix_en_p1);
      bypass_act <= byp_nxt_p1;
    end
  end

`ifdef GAMMA_DE_COUNT_EN
  // Active pixel counter: counts emitted de cycles, published and restarted
  // at each aligned vs rising edge. A de on the edge cycle itself belongs to
  // the new frame.
  logic [DE_COUNT_W-1:0] de_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_run   <= '0;
      de_count <= '0;
    end else if (vs_rise_p1) begin
      de_count <= de_run;
      de_run   <= DE_COUNT_W'(pix_en_p1);
    end else if (pix_en_p1) begin
      de_run   <= de_run + DE_COUNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_gamma_lut_stage.sv
// ---------------------------------------------------------------------------
// tb_gamma_lut_stage
//   Directed bench for gamma_lut_stage. Two instances run side by side on
//   the same stimulus: u1 with ROM_LAT=1 and u2 with ROM_LAT=2, each with its
//   own ROM model (r = a^0xFF, g = a^0x0F, b = a^0xF0) of matching latency.
//   Stimulus advances one clock per cyc() call; outputs are read 1 time unit
//   after the rising edge.
// ---------------------------------------------------------------------------
module tb_gamma_lut_stage;
  import gamma_pkg::*;

  logic clk;
  logic rst;
  logic i_vs, i_hs, i_de, bypass;
  logic [7:0] i_r, i_g, i_b;

  logic [7:0] a1_r, a1_g, a1_b, d1_r, d1_g, d1_b;
  logic [7:0] a2_r, a2_g, a2_b, d2_r, d2_g, d2_b;
  logic [7:0] m2_r, m2_g, m2_b;
  logic       u1_vs, u1_hs, u1_de, u1_byp;
  logic       u2_vs, u2_hs, u2_de, u2_byp;
  logic [7:0] u1_r, u1_g, u1_b, u2_r, u2_g, u2_b;
`ifdef GAMMA_DE_COUNT_EN
  logic [DE_COUNT_W-1:0] u1_cnt, u2_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gamma_lut_stage #(.DATA_W(8), .ROM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .bypass(bypass),
    .rom_addr_r(a1_r), .rom_addr_g(a1_g), .rom_addr_b(a1_b),
    .rom_data_r(d1_r), .rom_data_g(d1_g), .rom_data_b(d1_b),
    .o_vs(u1_vs), .o_hs(u1_hs), .o_de(u1_de),
    .o_r(u1_r), .o_g(u1_g), .o_b(u1_b), .bypass_act(u1_byp)
`ifdef GAMMA_DE_COUNT_EN
    , .de_count(u1_cnt)
`endif
  );

  gamma_lut_stage #(.DATA_W(8), .ROM_LAT(2)) u2 (
    .clk(clk), .rst(rst), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .bypass(bypass),
    .rom_addr_r(a2_r), .rom_addr_g(a2_g), .rom_addr_b(a2_b),
    .rom_data_r(d2_r), .rom_data_g(d2_g), .rom_data_b(d2_b),
    .o_vs(u2_vs), .o_hs(u2_hs), .o_de(u2_de),
    .o_r(u2_r), .o_g(u2_g), .o_b(u2_b), .bypass_act(u2_byp)
`ifdef GAMMA_DE_COUNT_EN
    , .de_count(u2_cnt)
`endif
  );

  // ROM models: 1-cycle (registered address) and 2-cycle (plus output reg).
  always @(posedge clk) begin
    d1_r <= a1_r ^ 8'hFF;
    d1_g <= a1_g ^ 8'h0F;
    d1_b <= a1_b ^ 8'hF0;
    m2_r <= a2_r ^ 8'hFF;
    m2_g <= a2_g ^ 8'h0F;
    m2_b <= a2_b ^ 8'hF0;
    d2_r <= m2_r;
    d2_g <= m2_g;
    d2_b <= m2_b;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

`ifdef GAMMA_DE_COUNT_EN
  task automatic chk24(input string tag, input logic [DE_COUNT_W-1:0] obs,
                       input logic [DE_COUNT_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
`endif

  // Present one cycle of video, then advance past the clock edge.
  task automatic cyc(input logic vs, input logic hs, input logic de, input logic [7:0] pix);
    i_vs = vs;
    i_hs = hs;
    i_de = de;
    i_r  = pix;
    i_g  = pix;
    i_b  = pix;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bypass = 1'b0;
    i_vs = 1'b0; i_hs = 1'b0; i_de = 1'b0; i_r = '0; i_g = '0; i_b = '0;

    // Reset: outputs clear, ROM address still follows pixels.
    cyc(0, 0, 1, 8'h40);
    cyc(0, 0, 1, 8'h40);
    chk8("rst_addr_r_u1", a1_r, 8'h40);
    chk8("rst_addr_b_u2", a2_b, 8'h40);
    chk1("rst_o_de_u1", u1_de, 1'b0);
    chk8("rst_o_r_u1", u1_r, 8'h00);
    chk1("rst_o_vs_u2", u2_vs, 1'b0);
    chk1("rst_byp_u1", u1_byp, 1'b0);

    // SYNC_WAIT: hs passes through, de and pixels held at 0.
    rst = 1'b0;
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h40);
    chk1("sw_o_hs_u1", u1_hs, 1'b1);
    cyc(0, 0, 1, 8'h40);
    chk1("sw_o_hs_u2", u2_hs, 1'b1);
    chk1("sw_o_de_u1", u1_de, 1'b0);
    chk8("sw_o_r_u1", u1_r, 8'h00);
    cyc(0, 0, 0, 8'h00);
    chk1("sw_o_de_u1_b", u1_de, 1'b0);
    chk1("sw_o_de_u2", u2_de, 1'b0);

    // First vs rise -> RUN; ROM values appear 2 (u1) / 3 (u2) cycles later.
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h40);
    chk1("run_o_vs_u1", u1_vs, 1'b1);
    chk1("run_byp_u1", u1_byp, 1'b0);
    cyc(0, 0, 1, 8'h40);
    chk1("run_o_de_u1", u1_de, 1'b1);
    chk8("run_o_r_u1", u1_r, 8'hBF);
    chk8("run_o_g_u1", u1_g, 8'h4F);
    chk8("run_o_b_u1", u1_b, 8'hB0);
    chk1("run_o_vs_u2", u2_vs, 1'b1);
    cyc(0, 0, 0, 8'h40);
    chk1("run_o_de_u2", u2_de, 1'b1);
    chk8("run_o_r_u2", u2_r, 8'hBF);
    cyc(0, 0, 0, 8'h40);
    chk1("blank_o_de_u1", u1_de, 1'b0);
    chk8("blank_o_r_u1", u1_r, 8'h00);
    chk1("run2_o_de_u2", u2_de, 1'b1);

    // Single-cycle de pulse.
    cyc(0, 0, 1, 8'h12);
    cyc(0, 0, 0, 8'h00);
    chk1("pulse_o_de_u1", u1_de, 1'b1);
    chk8("pulse_o_r_u1", u1_r, 8'hED);
    chk1("pulse_pre_de_u2", u2_de, 1'b0);
    cyc(0, 0, 0, 8'h00);
    chk1("pulse_o_de_u2", u2_de, 1'b1);
    chk8("pulse_o_r_u2", u2_r, 8'hED);
    chk1("pulse_post_de_u1", u1_de, 1'b0);
    cyc(0, 0, 0, 8'h00);
    chk1("pulse_post_de_u2", u2_de, 1'b0);

    // Bypass raised mid-frame: no effect until the next vs rise.
    bypass = 1'b1;
    cyc(0, 0, 1, 8'h40);
    cyc(0, 0, 1, 8'h40);
    chk8("midbyp_o_r_u1", u1_r, 8'hBF);
    chk1("midbyp_byp_u1", u1_byp, 1'b0);
    cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h40);
    chk1("byp_o_vs_u1", u1_vs, 1'b1);
    chk1("byp_act_u1", u1_byp, 1'b1);
    cyc(0, 0, 0, 8'h00);
    chk1("byp_o_de_u1", u1_de, 1'b1);
    chk8("byp_o_r_u1", u1_r, 8'h40);
    chk8("byp_o_g_u1", u1_g, 8'h40);
    chk1("byp_act_u2", u2_byp, 1'b1);
    cyc(0, 0, 0, 8'h00);
    chk8("byp_o_r_u2", u2_r, 8'h40);

    // Bypass changed exactly in the aligned vs edge cycle of each instance.
    cyc(1, 0, 0, 8'h00);
    bypass = 1'b0;
    cyc(0, 0, 0, 8'h00);
    chk1("edge_byp_u1", u1_byp, 1'b0);
    bypass = 1'b1;
    cyc(0, 0, 1, 8'h40);
    chk1("edge_byp_u1_hold", u1_byp, 1'b0);
    chk1("edge_byp_u2", u2_byp, 1'b1);
    cyc(0, 0, 0, 8'h00);
    chk8("edge_o_r_u1", u1_r, 8'hBF);
    chk1("edge_byp_u1_hold2", u1_byp, 1'b0);
    cyc(0, 0, 0, 8'h00);
    chk8("edge_o_r_u2", u2_r, 8'h40);

    // Reset mid-line: blank immediately, wait for a new vs rise.
    bypass = 1'b0;
    cyc(0, 0, 1, 8'h40);
    rst = 1'b1;
    cyc(0, 0, 1, 8'h40);
    chk1("mrst_o_de_u1", u1_de, 1'b0);
    chk8("mrst_o_r_u1", u1_r, 8'h00);
    chk1("mrst_o_de_u2", u2_de, 1'b0);
    chk1("mrst_byp_u2", u2_byp, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 8'h40);
      chk1("mrst_hold_de_u1", u1_de, 1'b0);
      chk1("mrst_hold_de_u2", u2_de, 1'b0);
    end

    // New frame: 4 lines x 16 active pixels, then the next vs.
    cyc(1, 0, 0, 8'h00);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 16; p++) begin
        cyc(0, 0, 1, 8'h40);
        if (l == 0 && p == 1) begin
          chk1("relock_o_de_u1", u1_de, 1'b1);
          chk8("relock_o_r_u1", u1_r, 8'hBF);
        end
        if (l == 0 && p == 2) begin
          chk1("relock_o_de_u2", u2_de, 1'b1);
        end
      end
      cyc(0, 1, 0, 8'h00);
      cyc(0, 1, 0, 8'h00);
    end
`ifdef GAMMA_DE_COUNT_EN
    chk24("cnt_prev_u1", u1_cnt, 24'd0);
`endif
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    chk1("frame_end_de_u2", u2_de, 1'b0);
`ifdef GAMMA_DE_COUNT_EN
    chk24("cnt_u1", u1_cnt, 24'd64);
    chk24("cnt_u2", u2_cnt, 24'd64);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
